// File: rtl/riscv_pkg.sv
// Shared definitions for the store path.
//   F3_SB / F3_SH / F3_SW : store funct3 encodings (same values as LB/LH/LW).
//   st_state_e            : store write sequencer states.
//   st_entry_t            : one buffered store request {addr, data, funct3}.
// The entry address field is sized for the widest supported bus; users keep
// only their low ADDR_W bits.
package riscv_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int ST_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } st_state_e;

  typedef struct packed {
    logic [ST_ADDR_MAX_W-1:0] addr;
    logic [31:0]              data;
    logic [2:0]               funct3;
  } st_entry_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO of store entries.
//   clk, reset  : clock, synchronous active-high reset (pointers/count only)
//   push, wdata : write an entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : entry at the read pointer
//   second      : entry behind the head, valid only when count > 1
//   full, empty, count : occupancy
module store_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  st_entry_t                wdata,
  input  logic                     pop,
  output st_entry_t                head,
  output st_entry_t                second,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  st_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/store_data_unit.sv
// Store formatting unit: buffers SB/SH/SW requests and turns each into one
// or two word-aligned memory writes with byte enables and lane-shifted data.
//   clk, reset          : clock, synchronous active-high reset
//   st_valid/st_ready   : request handshake (st_ready = FIFO not full)
//   st_addr/st_data/st_funct3 : byte address, store data, access size
//   st_err              : one-cycle pulse after an illegal funct3 is dropped
//   mem_wr_en/mem_ready : write handshake toward data memory
//   mem_addr/mem_wdata/mem_be : word address, lane data, byte enables
//   busy                : stores pending or a write in flight
module store_data_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              st_err,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [7:0] lane_be8(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be4;
    case (f3)
      F3_SB:   be4 = 4'b0001;
      F3_SH:   be4 = 4'b0011;
      default: be4 = 4'b1111;
    endcase
    return {4'b0000, be4} << off;
  endfunction

  function automatic logic [63:0] lane_d64(input logic [2:0] f3, input logic [31:0] data,
                                           input logic [1:0] off);
    logic [31:0] dm;
    case (f3)
      F3_SB:   dm = {24'b0, data[7:0]};
      F3_SH:   dm = {16'b0, data[15:0]};
      default: dm = data;
    endcase
    return {32'b0, dm} << {off, 3'b000};
  endfunction

  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  st_entry_t       push_entry;
  st_entry_t       head;
  st_entry_t       second;
  logic            accept;
  logic            push;
  logic            pop;
  logic            retire;

  // Request acceptance: illegal sizes are consumed but never buffered.
  assign st_ready   = !fifo_full;
  assign accept     = st_valid && st_ready;
  assign push       = accept && f3_legal(st_funct3);
  assign push_entry = '{addr: ST_ADDR_MAX_W'(st_addr), data: st_data, funct3: st_funct3};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .head   (head),
    .second (second),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  if (ADDR_W < ST_ADDR_MAX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{head.addr[ST_ADDR_MAX_W-1:ADDR_W],
                              second.addr[ST_ADDR_MAX_W-1:ADDR_W]};
  end

  // ---- stage p0: lane formatting of the head entry and the one behind it ----
  // The second entry is formatted too so that a retiring write can hand over
  // to the next store without an idle cycle.
  logic [ADDR_W-1:0] h_base_p0;
  logic [7:0]        h_be8_p0;
  logic [63:0]       h_d64_p0;
  logic              h_split_p0;
  logic [ADDR_W-1:0] n_base_p0;
  logic [7:0]        n_be8_p0;
  logic [63:0]       n_d64_p0;

  assign h_base_p0  = {head.addr[ADDR_W-1:2], 2'b00};
  assign h_be8_p0   = lane_be8(head.funct3, head.addr[1:0]);
  assign h_d64_p0   = lane_d64(head.funct3, head.data, head.addr[1:0]);
  assign h_split_p0 = |h_be8_p0[7:4];
  assign n_base_p0  = {second.addr[ADDR_W-1:2], 2'b00};
  assign n_be8_p0   = lane_be8(second.funct3, second.addr[1:0]);
  assign n_d64_p0   = lane_d64(second.funct3, second.data, second.addr[1:0]);

  // ---- stage p1: registered memory write request ----
  st_state_e         state_p1, state_d;
  logic              vld_p1, vld_d;
  logic [ADDR_W-1:0] addr_p1, addr_d;
  logic [3:0]        be_p1, be_d;
  logic [31:0]       wdata_p1, wdata_d;
  logic              err_p1;

  always_comb begin
    state_d = state_p1;
    vld_d   = vld_p1;
    addr_d  = addr_p1;
    be_d    = be_p1;
    wdata_d = wdata_p1;
    pop     = 1'b0;
    retire  = 1'b0;
    unique case (state_p1)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = BEAT0;
          vld_d   = 1'b1;
          addr_d  = h_base_p0;
          be_d    = h_be8_p0[3:0];
          wdata_d = h_d64_p0[31:0];
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (h_split_p0) begin
            state_d = BEAT1;
            addr_d  = h_base_p0 + ADDR_W'(4);
            be_d    = h_be8_p0[7:4];
            wdata_d = h_d64_p0[63:32];
          end else begin
            retire = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) retire = 1'b1;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
    // A finished store either hands straight over to the next buffered one
    // or drops the request line.
    if (retire) begin
      pop = 1'b1;
      if (fifo_count > CW'(1)) begin
        state_d = BEAT0;
        vld_d   = 1'b1;
        addr_d  = n_base_p0;
        be_d    = n_be8_p0[3:0];
        wdata_d = n_d64_p0[31:0];
      end else begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      be_p1    <= '0;
      wdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_d;
      vld_p1   <= vld_d;
      addr_p1  <= addr_d;
      be_p1    <= be_d;
      wdata_p1 <= wdata_d;
      err_p1   <= accept && !f3_legal(st_funct3);
    end
  end

  assign mem_wr_en = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_be    = be_p1;
  assign mem_wdata = wdata_p1;
  assign st_err    = err_p1;
  assign busy      = (fifo_count != '0) || (state_p1 != IDLE);

endmodule

// File: tb/tb_store_data_unit.sv
module tb_store_data_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        st_err;
  logic        mem_wr_en;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;

  store_data_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .st_err    (st_err),
    .mem_wr_en (mem_wr_en),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wr_t;

  wr_t expq[$];
  wr_t obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Reference: walk the stored bytes one at a time and group them by the
  // word they land in.
  function automatic void model_push(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] f3);
    int  n;
    wr_t cur;
    bit  have;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    have = 1'b0;
    cur = '{32'h0, 4'h0, 32'h0};
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba;
      logic [31:0] wa;
      int          lane;
      ba   = a + 32'(i);
      wa   = ba & 32'hFFFF_FFFC;
      lane = int'(ba[1:0]);
      if (!have || wa != cur.addr) begin
        if (have) expq.push_back(cur);
        cur  = '{wa, 4'h0, 32'h0};
        have = 1'b1;
      end
      cur.be[lane] = 1'b1;
      cur.wdata[lane*8 +: 8] = d[i*8 +: 8];
    end
    expq.push_back(cur);
  endfunction

  // Monitor, sampled on the falling edge; predicts what the next rising
  // edge will do.
  logic last_rst = 1'b1;
  logic err_pend = 1'b0;
  logic stall = 1'b0;
  wr_t  held;
  wr_t  e;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      err_pend = 1'b0;
      stall    = 1'b0;
      last_rst = 1'b1;
    end else begin
      if (last_rst) begin
        chk1("rst_wr_en", mem_wr_en, 1'b0);
        chk ("rst_addr", mem_addr, 32'h0);
        chk ("rst_wdata", mem_wdata, 32'h0);
        chk ("rst_be", 32'(mem_be), 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", st_ready, 1'b1);
      end
      last_rst = 1'b0;
      chk1("busy", busy, expq.size() != 0);
      chk1("st_err", st_err, err_pend);
      if (stall) begin
        chk1("hold_wr_en", mem_wr_en, 1'b1);
        chk ("hold_addr", mem_addr, held.addr);
        chk ("hold_be", 32'(mem_be), 32'(held.be));
        chk ("hold_wdata", mem_wdata, held.wdata);
      end
      if (mem_wr_en) chk1("be_nonzero", mem_be != 4'h0, 1'b1);
      stall = mem_wr_en && !mem_ready;
      held  = '{mem_addr, mem_be, mem_wdata};
      if (mem_wr_en && mem_ready) begin
        obs.push_back('{mem_addr, mem_be, mem_wdata});
        if (expq.size() == 0) begin
          chk1("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_be", 32'(mem_be), 32'(e.be));
          chk("wr_wdata", mem_wdata, e.wdata);
        end
      end
      err_pend = st_valid && st_ready && (st_funct3 > 3'd2);
      if (st_valid && st_ready && st_funct3 <= 3'd2) model_push(st_addr, st_data, st_funct3);
    end
  end

  task automatic drive_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
    st_valid  = 1'b1;
    @(posedge clk);
    #1;
    st_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("idle_timeout", busy, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    int          nw;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] d1;
  } vec_t;

  vec_t        tv[9];
  logic [31:0] bp_data[5];
  logic [31:0] s_addr;
  logic [31:0] s_wdata;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{32'h1002, 32'hDEADBEEF, 3'b000, 1, 32'h1000, 4'b0100, 32'h00EF0000, 32'h0, 4'h0, 32'h0};
    tv[1] = '{32'h2003, 32'h0000A1B2, 3'b001, 2, 32'h2000, 4'b1000, 32'hB2000000, 32'h2004, 4'b0001, 32'h000000A1};
    tv[2] = '{32'h3001, 32'h11223344, 3'b010, 2, 32'h3000, 4'b1110, 32'h22334400, 32'h3004, 4'b0001, 32'h00000011};
    tv[3] = '{32'h4000, 32'hCAFEBABE, 3'b010, 1, 32'h4000, 4'b1111, 32'hCAFEBABE, 32'h0, 4'h0, 32'h0};
    tv[4] = '{32'h5002, 32'h12345678, 3'b001, 1, 32'h5000, 4'b1100, 32'h56780000, 32'h0, 4'h0, 32'h0};
    tv[5] = '{32'h6003, 32'h000000A5, 3'b000, 1, 32'h6000, 4'b1000, 32'hA5000000, 32'h0, 4'h0, 32'h0};
    tv[6] = '{32'h7003, 32'hAABBCCDD, 3'b010, 2, 32'h7000, 4'b1000, 32'hDD000000, 32'h7004, 4'b0111, 32'h00AABBCC};
    tv[7] = '{32'hFFFFFFFE, 32'h01020304, 3'b010, 2, 32'hFFFFFFFC, 4'b1100, 32'h03040000, 32'h00000000, 4'b0011, 32'h00000102};
    tv[8] = '{32'h8001, 32'hFFFF9876, 3'b001, 1, 32'h8000, 4'b0110, 32'h00987600, 32'h0, 4'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;

    // First-write latency of a single SB.
    drive_push(32'h1002, 32'hDEADBEEF, 3'b000);
    chk1("lat_wr_en_push", mem_wr_en, 1'b0);
    chk1("lat_busy_push", busy, 1'b1);
    @(posedge clk);
    #1;
    chk1("lat_wr_en_issue", mem_wr_en, 1'b1);
    chk ("lat_addr", mem_addr, 32'h1000);
    chk ("lat_be", 32'(mem_be), 32'h4);
    chk ("lat_wdata", mem_wdata, 32'h00EF0000);
    @(posedge clk);
    #1;
    chk1("lat_wr_en_done", mem_wr_en, 1'b0);
    chk1("lat_busy_done", busy, 1'b0);

    // Formatting table.
    for (int i = 0; i < 9; i++) begin
      obs.delete();
      drive_push(tv[i].addr, tv[i].data, tv[i].f3);
      wait_idle(20);
      chk($sformatf("tv%0d_nwrites", i), 32'(obs.size()), 32'(tv[i].nw));
      if (obs.size() > 0) begin
        chk($sformatf("tv%0d_a0", i), obs[0].addr, tv[i].a0);
        chk($sformatf("tv%0d_b0", i), 32'(obs[0].be), 32'(tv[i].b0));
        chk($sformatf("tv%0d_d0", i), obs[0].wdata, tv[i].d0);
      end
      if (tv[i].nw == 2 && obs.size() > 1) begin
        chk($sformatf("tv%0d_a1", i), obs[1].addr, tv[i].a1);
        chk($sformatf("tv%0d_b1", i), 32'(obs[1].be), 32'(tv[i].b1));
        chk($sformatf("tv%0d_d1", i), obs[1].wdata, tv[i].d1);
      end
    end

    // Backpressure: fill the FIFO while memory stalls.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_data[i] = 32'hA0B0C000 + 32'(i);
      st_addr    = 32'h100 * 32'(i + 1);
      st_data    = bp_data[i];
      st_funct3  = 3'b010;
      st_valid   = 1'b1;
      chk1($sformatf("bp_ready%0d", i), st_ready, i < 4);
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    chk1("bp_full_ready", st_ready, 1'b0);
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    repeat (3) @(posedge clk);
    #1;
    chk1("bp_stall_wr_en", mem_wr_en, 1'b1);
    chk ("bp_stall_addr", mem_addr, s_addr);
    chk ("bp_stall_wdata", mem_wdata, s_wdata);
    chk ("bp_stall_first", mem_addr, 32'h100);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("bp_wr_en%0d", i), mem_wr_en, 1'b1);
      chk ($sformatf("bp_addr%0d", i), mem_addr, 32'h100 * 32'(i + 1));
      chk ($sformatf("bp_wdata%0d", i), mem_wdata, bp_data[i]);
      @(posedge clk);
      #1;
    end
    chk1("bp_busy_clear", busy, 1'b0);
    chk1("bp_wr_en_clear", mem_wr_en, 1'b0);

    // Illegal funct3 is dropped with a one-cycle error pulse.
    drive_push(32'h9000, 32'h12345678, 3'b011);
    chk1("err_pulse", st_err, 1'b1);
    chk1("err_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk1("err_clear", st_err, 1'b0);
    chk1("err_no_wr", mem_wr_en, 1'b0);
    chk1("err_busy2", busy, 1'b0);

    // Reset while the second beat of a split SW is pending.
    drive_push(32'h3001, 32'h11223344, 3'b010);
    @(posedge clk);
    #1;
    chk1("rs_beat0_wr_en", mem_wr_en, 1'b1);
    chk ("rs_beat0_be", 32'(mem_be), 32'hE);
    @(posedge clk);
    #1;
    chk ("rs_beat1_be", 32'(mem_be), 32'h1);
    chk ("rs_beat1_addr", mem_addr, 32'h3004);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk1("rs_wr_en", mem_wr_en, 1'b0);
    chk1("rs_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("rs_no_beat1_%0d", i), mem_wr_en, 1'b0);
    end

    // Random traffic against the byte-level model.
    for (int c = 0; c < 400; c++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_addr   = $urandom;
      st_data   = $urandom;
      st_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2));
      mem_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    wait_idle(50);
    @(posedge clk);
    #1;
    chk1("drain_empty", expq.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/store_data_unit.md
Name: store_data_unit

Overview:
- Write-side counterpart of the load extension path: formats SB/SH/SW stores into word-aligned memory writes with byte enables and lane-shifted data.
- Sits between the execute stage and the data memory write port.
- Buffers stores in a small FIFO so the pipeline does not stall on memory backpressure.
- Splits misaligned stores that straddle a word boundary into two word writes.

Parameters:
- DEPTH, 4, store FIFO entries; power of two, minimum 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  FIFO can accept a request (= !full).
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  store data; the low bytes are used for SB/SH.
- st_funct3  in  3  000 = SB, 001 = SH, 010 = SW.
- st_err  out  1  one-cycle pulse: request with an illegal funct3 was dropped.
- mem_wr_en  out  1  memory write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 00.
- mem_wdata  out  32  lane-positioned write data.
- mem_be  out  4  byte enables.
- busy  out  1  FIFO not empty or a write is in flight; used by the load-hazard logic to hold loads.

Behaviour:
- Reset values:
  - FIFO pointers and count cleared.
  - FSM = IDLE.
  - mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
  - st_err = 0, busy = 0.
  - st_ready = 1 from the first cycle after reset deasserts.
- Accept:
  - A request is pushed when st_valid && st_ready.
  - Legal funct3 values are 000, 001 and 010.
  - An illegal funct3 that is otherwise accepted is not pushed; st_err pulses the next cycle.
- FIFO:
  - st_ready = !full; there is no bypass.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - When full, st_ready = 0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- Formatting of the head entry (combinational from the head; off = addr[1:0]):
  - Base enable be4: SB = 0001, SH = 0011, SW = 1111.
  - be8 = {4'b0, be4} << off.
  - d64 = {32'b0, data masked to the access size} << (8*off).
  - Beat 0: addr = {addr[ADDR_W-1:2], 2'b00}, be = be8[3:0], wdata = d64[31:0].
  - Beat 1: only when be8[7:4] != 0 (SH at off 3, SW at off != 0); addr = beat-0 addr + 4 (wraps at 2^ADDR_W), be = be8[7:4], wdata = d64[63:32].
- FSM states IDLE, BEAT0, BEAT1:
  - IDLE -> BEAT0 when the FIFO is non-empty. mem_* are registered from the head entry, so first mem_wr_en is 1 cycle after the push is visible.
  - BEAT0 with mem_ready:
    - No split: pop the entry, then go to BEAT0 if more entries remain, else IDLE.
    - Split: go to BEAT1 and load the beat-1 fields.
  - BEAT1 with mem_ready: pop the entry, then go to BEAT0 or IDLE as above.
  - Throughput: back-to-back aligned stores issue one write per cycle when mem_ready stays high.
- Handshake:
  - While mem_wr_en = 1, mem_addr, mem_wdata and mem_be are held stable until mem_ready.
  - mem_ready while mem_wr_en = 0 is ignored.
  - mem_be is never 0 while mem_wr_en = 1.
- busy = (count != 0) || (state != IDLE).
- Reset mid-operation: an in-flight write is abandoned, mem_wr_en drops the next cycle, and FIFO contents are discarded.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 store constants F3_SB/F3_SH/F3_SW, reusing the same encodings as the load path.
  - FSM state enum.
  - Store entry struct {addr, data, funct3}.
- One sub-module, store_fifo: parameterised synchronous FIFO with push, pop, full, empty and count.
- Lane formatting stays inline as combinational logic.

Test Plan:
- SB addr 0x1002, data 0xDEADBEEF, mem_ready = 1 -> one write: addr 0x1000, be 0100, wdata[23:16] = 0xEF.
- SH addr 0x2003, data 0x0000A1B2 -> two writes:
  - 0x2000, be 1000, wdata[31:24] = 0xB2;
  - then 0x2004, be 0001, wdata[7:0] = 0xA1.
- SW addr 0x3001, data 0x11223344 -> two writes:
  - 0x3000, be 1110, wdata = 0x22334400;
  - then 0x3004, be 0001, wdata = 0x00000011.
- mem_ready held 0 with 5 SW pushes attempted (DEPTH 4):
  - st_ready drops after the 4th; outputs stay stable.
  - Release mem_ready -> 4 writes in order, busy clears the cycle after the last.
- funct3 = 011 with st_valid -> no write issued, st_err pulses once, busy stays 0.
- Reset asserted during BEAT1 of a split SW -> mem_wr_en = 0 and busy = 0 next cycle; beat 1 is never issued.
